// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ byte producers.
// Optional build macro UART_ARB_ID_PREFIX_EN sends a {4'hA, grant_id} header before each byte.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 arb_busy
);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitHi,
    StWaitLo
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            hi_wait_q, hi_wait_d;
`ifdef UART_ARB_ID_PREFIX_EN
  logic [7:0]      payload_q, payload_d;
  logic            hdr_q, hdr_d;
`endif

  logic               found;
  logic [ID_W-1:0]    pick;
  logic [7:0]         pick_byte;
  logic [NUM_REQ-1:0] valid_sh;
  int unsigned        idx;

  // Search starts just after the last winner; the last winner itself is tried last.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_byte = 8'h00;
    valid_sh  = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx      = (32'(rr_ptr_q) + k) % NUM_REQ;
      valid_sh = req_valid >> idx;
      if (!found && valid_sh[0]) begin
        found     = 1'b1;
        pick      = ID_W'(idx);
        pick_byte = 8'(req_data >> (8 * idx));
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    hi_wait_d  = hi_wait_q;
`ifdef UART_ARB_ID_PREFIX_EN
    payload_d  = payload_q;
    hdr_d      = hdr_q;
`endif
    req_ready  = '0;
    tx_start   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // No handshake while rst is high: the accepted byte would be lost at the edge.
        if (found && !rst) begin
          req_ready  = NUM_REQ'(1) << pick;
          grant_id_d = pick;
          rr_ptr_d   = pick;
`ifdef UART_ARB_ID_PREFIX_EN
          tx_data_d  = {4'hA, 4'(pick)};
          payload_d  = pick_byte;
          hdr_d      = 1'b1;
`else
          tx_data_d  = pick_byte;
`endif
          state_d    = StStart;
        end
      end
      StStart: begin
        if (!tx_busy && !rst) begin
          tx_start  = 1'b1;
          hi_wait_d = 1'b0;
          state_d   = StWaitHi;
        end
      end
      StWaitHi: begin
        // UART missed the pulse: give it two cycles, then pulse again.
        if (tx_busy) begin
          state_d = StWaitLo;
        end else if (hi_wait_q) begin
          state_d = StStart;
        end else begin
          hi_wait_d = 1'b1;
        end
      end
      StWaitLo: begin
        if (!tx_busy) begin
`ifdef UART_ARB_ID_PREFIX_EN
          if (hdr_q) begin
            hdr_d     = 1'b0;
            tx_data_d = payload_q;
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_data_q  <= 8'h00;
      grant_id_q <= '0;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      hi_wait_q  <= 1'b0;
`ifdef UART_ARB_ID_PREFIX_EN
      payload_q  <= 8'h00;
      hdr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      hi_wait_q  <= hi_wait_d;
`ifdef UART_ARB_ID_PREFIX_EN
      payload_q  <= payload_d;
      hdr_q      <= hdr_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign arb_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: 4-cycle-per-bit UART stand-in, line decoder and a
// round-robin reference model; honours UART_ARB_ID_PREFIX_EN.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef UART_ARB_ID_PREFIX_EN
  localparam int BPG = 2;
`else
  localparam int BPG = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .arb_busy (arb_busy)
  );

  // UART stand-in: 10 bits x 4 cycles; never reset by the arbiter's rst.
  logic       force_busy = 1'b0;
  logic       uart_en = 1'b1;
  logic       m_busy = 1'b0;
  logic [5:0] m_cnt = 6'd0;
  logic [9:0] m_frame = 10'h3ff;
  logic       line;

  assign tx_busy = m_busy | force_busy;
  assign line    = m_busy ? m_frame[m_cnt[5:2]] : 1'b1;

  always @(posedge clk) begin
    if (!m_busy) begin
      if (tx_start && uart_en) begin
        m_busy  <= 1'b1;
        m_cnt   <= 6'd0;
        m_frame <= {1'b1, tx_data, 1'b0};
      end
    end else if (m_cnt == 6'd39) begin
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 6'd1;
    end
  end

  // Line decoder: samples mid-bit, LSB first.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte = 8'h00;
  logic       rx_active = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (line == 1'b0) begin
        rx_active = 1'b1;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clk);
          rx_byte[b[2:0]] = line;
        end
        repeat (4) @(negedge clk);
        rx_q.push_back(rx_byte);
        rx_active = 1'b0;
      end
    end
  end

  int n_total = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Producer byte stores, one per requester.
  logic [7:0] src_mem [4][64];
  logic [6:0] head [4];
  logic [6:0] tail [4];

  logic [7:0] exp_q[$];
  logic [1:0] last_id = 2'd3;
  logic       start_due = 1'b0;
  logic [7:0] due_byte = 8'h00;
  int         cyc_no = 0;
  int         n_starts = 0;
  int         n_grants = 0;
  int         last_start = 0;
  int         prev_start = 0;
  logic [3:0] snap_ready;
  logic       snap_start;
  logic [1:0] snap_gid;
  logic       snap_busy;
  logic [7:0] snap_data;

  // Winner = first valid index at or after last+1, modulo 4.
  function automatic logic [1:0] pick_next(input logic [3:0] v, input logic [1:0] last);
    logic [1:0] cand;
    pick_next = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + k[1:0];
      if (v[cand]) pick_next = cand;
    end
  endfunction

  task automatic refresh_inputs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i[1:0]]  = (head[i[1:0]] != tail[i[1:0]]);
      req_data[8*i +: 8] = src_mem[i[1:0]][head[i[1:0]][5:0]];
    end
  endtask

  task automatic push_req(input logic [1:0] r, input logic [7:0] b);
    src_mem[r][tail[r][5:0]] = b;
    tail[r] = tail[r] + 7'd1;
    refresh_inputs();
  endtask

  task automatic clear_ptrs();
    for (int i = 0; i < 4; i++) begin
      head[i[1:0]] = '0;
      tail[i[1:0]] = '0;
    end
    refresh_inputs();
  endtask

  // One clock: observe at negedge, update inputs 1 time unit after posedge.
  task automatic cycle();
    logic [1:0] w;
    logic [3:0] pop_mask;
    @(negedge clk);
    cyc_no++;
    snap_ready = req_ready;
    snap_start = tx_start;
    snap_gid   = grant_id;
    snap_busy  = arb_busy;
    snap_data  = tx_data;
    if (start_due) begin
      start_due = 1'b0;
      check_eq("start_latency", tx_start, 1);
      check_eq("start_data", tx_data, due_byte);
    end
    if (tx_start) begin
      n_starts++;
      prev_start = last_start;
      last_start = cyc_no;
      check_eq("start_vs_busy", tx_busy, 0);
    end
    pop_mask = '0;
    if (!rst && !arb_busy && req_valid != 4'b0) begin
      w = pick_next(req_valid, last_id);
      check_eq("grant", req_ready, 4'b0001 << w);
      last_id = w;
      n_grants++;
`ifdef UART_ARB_ID_PREFIX_EN
      exp_q.push_back({4'hA, 2'b00, w});
      due_byte = {4'hA, 2'b00, w};
`else
      due_byte = src_mem[w][head[w][5:0]];
`endif
      exp_q.push_back(src_mem[w][head[w][5:0]]);
      start_due = !force_busy && !m_busy;
      pop_mask  = 4'b0001 << w;
    end else if (req_ready != 4'b0) begin
      check_eq("ready_outside_idle", req_ready, 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (pop_mask[i[1:0]]) head[i[1:0]] = head[i[1:0]] + 7'd1;
    refresh_inputs();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    last_id   = 2'd3;
    start_due = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 8000 && !(req_valid == 4'b0 && !arb_busy && !m_busy && !rx_active)) begin
      cycle();
      n++;
    end
    if (n >= 8000) check_eq("drain_timeout", n, 0);
    repeat (4) cycle();
  endtask

  task automatic compare_rx();
    check_eq("rx_count", rx_q.size(), exp_q.size());
    for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++)
      check_eq("rx_byte", rx_q[k], exp_q[k]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    cycle();
    check_eq({tag, "_ready"}, snap_ready, 0);
    check_eq({tag, "_start"}, snap_start, 0);
    check_eq({tag, "_data"}, snap_data, 0);
    check_eq({tag, "_gid"}, snap_gid, 0);
    check_eq({tag, "_busy"}, snap_busy, 0);
  endtask

  initial begin
    int s0;
    int n;
    int gap;
    logic [3:0] mask;
    for (int i = 0; i < 4; i++) begin
      head[i[1:0]] = '0;
      tail[i[1:0]] = '0;
      for (int j = 0; j < 64; j++) src_mem[i[1:0]][j[5:0]] = 8'h00;
    end
    @(posedge clk);
    #1;
    do_reset();
    check_reset_state("rst");

    // Single request from requester 2.
    push_req(2'd2, 8'h5A);
    cycle();
    check_eq("t1_ready", snap_ready, 4'b0100);
    cycle();
    check_eq("t1_gid", snap_gid, 2);
    check_eq("t1_start", snap_start, 1);
    check_eq("t1_busy", snap_busy, 1);
    cycle();
    check_eq("t1_start_pulse", snap_start, 0);
    drain();
    check_eq("t1_idle", snap_busy, 0);
    check_eq("t1_rx_n", rx_q.size(), BPG);
    if (rx_q.size() > 0) check_eq("t1_rx", rx_q[rx_q.size() - 1], 8'h5A);
    compare_rx();
    clear_ptrs();

    // All four valid and held.
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) push_req(i[1:0], 8'(8'h10 + i));
    drain();
    check_eq("t2_rx_n", rx_q.size(), 12 * BPG);
    for (int k = 0; k < 12 && k * BPG + BPG - 1 < rx_q.size(); k++)
      check_eq("t2_order", rx_q[k * BPG + BPG - 1], 8'(8'h10 + k % 4));
    compare_rx();
    clear_ptrs();

    // UART busy before the grant.
    force_busy = 1'b1;
    push_req(2'd1, 8'h3C);
    cycle();
    s0 = n_starts;
    repeat (6) cycle();
    check_eq("t3_held_starts", n_starts - s0, 0);
    check_eq("t3_held_busy", snap_busy, 1);
    force_busy = 1'b0;
    drain();
    check_eq("t3_starts", n_starts - s0, BPG);
    compare_rx();
    clear_ptrs();

    // Reset in the middle of a frame.
    do_reset();
    push_req(2'd0, 8'h77);
    repeat (11) cycle();
    check_eq("t4_mid_busy", snap_busy, 1);
    do_reset();
`ifdef UART_ARB_ID_PREFIX_EN
    void'(exp_q.pop_back());
`endif
    check_reset_state("t4_rst");
    for (int i = 0; i < 4; i++) push_req(i[1:0], 8'(8'h40 + i));
    cycle();
    check_eq("t4_first_grant", snap_ready, 4'b0001);
    drain();
    compare_rx();
    clear_ptrs();

    // UART ignores the first pulses.
    uart_en = 1'b0;
    s0 = n_starts;
    push_req(2'd1, 8'h96);
    n = 0;
    while (n_starts - s0 < 2 && n < 20) begin
      cycle();
      n++;
    end
    check_eq("t5_restart_gap", last_start - prev_start, 3);
    uart_en = 1'b1;
    drain();
    check_eq("t5_starts", n_starts - s0, 2 + BPG);
    compare_rx();
    clear_ptrs();

    // Requester 3, checks the header/payload split.
    s0 = n_grants;
    push_req(2'd3, 8'hC3);
    drain();
    check_eq("t6_grants", n_grants - s0, 1);
    check_eq("t6_rx_n", rx_q.size(), BPG);
`ifdef UART_ARB_ID_PREFIX_EN
    if (rx_q.size() > 0) check_eq("t6_hdr", rx_q[0], 8'hA3);
`endif
    if (rx_q.size() > 0) check_eq("t6_payload", rx_q[rx_q.size() - 1], 8'hC3);
    compare_rx();
    clear_ptrs();

    // Random arrivals.
    for (int r = 0; r < 20; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
        if (mask[i[1:0]]) push_req(i[1:0], 8'($urandom));
      gap = $urandom_range(0, 50);
      repeat (gap) cycle();
    end
    drain();
    compare_rx();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
